// File: rtl/rf_alu_datapath.sv
// 4-bit processor datapath: 4x4 register file, A/G/DP registers, add/sub unit, 7-seg driver.
// Latency: RF read and adder are combinational, registers update on the clock edge; no backpressure.
module rf_alu_datapath #(
  parameter int WIDTH        = 4,
  parameter int REFRESH_BITS = 17
) (
  input  logic             fpga_clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic [1:0]       addr_x,
  input  logic [1:0]       addr_y,
  input  logic             rd_x,
  input  logic             rd_y,
  input  logic             wr_x,
  input  logic             a_in,
  input  logic             g_in,
  input  logic             dp_in,
  input  logic             add_sub,
  input  logic             iout,
  input  logic [WIDTH-1:0] imm,
  input  logic [3:0]       sm_state,
  output logic [WIDTH-1:0] rf_dataout,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] g_out,
  output logic [WIDTH-1:0] dp_out,
  output logic [WIDTH-1:0] adder_out,
  output logic [6:0]       seg,
  output logic [7:0]       an
);

  logic [WIDTH-1:0]        rf [4];
  logic [WIDTH-1:0]        b_opnd;
  logic [REFRESH_BITS-1:0] refresh_cnt;
  logic [3:0]              disp_nib;

  // Active-low segment pattern, seg[0]=a .. seg[6]=g.
  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] p;
    case (v)
      4'h0: p = 7'h3F;
      4'h1: p = 7'h06;
      4'h2: p = 7'h5B;
      4'h3: p = 7'h4F;
      4'h4: p = 7'h66;
      4'h5: p = 7'h6D;
      4'h6: p = 7'h7D;
      4'h7: p = 7'h07;
      4'h8: p = 7'h7F;
      4'h9: p = 7'h6F;
      4'hA: p = 7'h77;
      4'hB: p = 7'h7C;
      4'hC: p = 7'h39;
      4'hD: p = 7'h5E;
      4'hE: p = 7'h79;
      default: p = 7'h71;
    endcase
    return ~p;
  endfunction

  always_ff @(posedge fpga_clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) rf[i] <= '0;
    end else if (wr_x) begin
      rf[addr_x] <= data_in;
    end
  end

  // rd_x has priority when both read enables are asserted.
  always_comb begin
    rf_dataout = '0;
    if (rd_x)      rf_dataout = rf[addr_x];
    else if (rd_y) rf_dataout = rf[addr_y];
  end

  always_ff @(posedge fpga_clk or posedge reset) begin
    if (reset) begin
      a_out  <= '0;
      g_out  <= '0;
      dp_out <= '0;
    end else begin
      if (a_in)  a_out  <= rf_dataout;
      if (g_in)  g_out  <= adder_out;
      if (dp_in) dp_out <= rf_dataout;
    end
  end

  assign b_opnd    = iout ? imm : rf_dataout;
  assign adder_out = add_sub ? (a_out - b_opnd) : (a_out + b_opnd);

  always_ff @(posedge fpga_clk or posedge reset) begin
    if (reset) refresh_cnt <= '0;
    else       refresh_cnt <= refresh_cnt + 1'b1;
  end

  always_comb begin
    disp_nib = dp_out[3:0];
    an       = 8'b1111_1110;
    if (refresh_cnt[REFRESH_BITS-1]) begin
      disp_nib = sm_state;
      an       = 8'b1111_1101;
    end
  end

  assign seg = hex7(disp_nib);

endmodule

// File: tb/tb_rf_alu_datapath.sv
// Directed-vector bench for rf_alu_datapath with hand-computed expectations.
module tb_rf_alu_datapath;
  logic       fpga_clk = 1'b0;
  logic       reset;
  logic [3:0] data_in, imm, sm_state;
  logic [1:0] addr_x, addr_y;
  logic       rd_x, rd_y, wr_x, a_in, g_in, dp_in, add_sub, iout;
  logic [3:0] rf_dataout, a_out, g_out, dp_out, adder_out;
  logic [6:0] seg;
  logic [7:0] an;

  int n_cmp = 0;
  int n_err = 0;
  int saw0 = 0;
  int saw1 = 0;

  // Active-low 7-seg patterns for 0..F, seg[0]=a.
  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  rf_alu_datapath #(.WIDTH(4), .REFRESH_BITS(5)) dut (
    .fpga_clk(fpga_clk), .reset(reset), .data_in(data_in), .addr_x(addr_x), .addr_y(addr_y),
    .rd_x(rd_x), .rd_y(rd_y), .wr_x(wr_x), .a_in(a_in), .g_in(g_in), .dp_in(dp_in),
    .add_sub(add_sub), .iout(iout), .imm(imm), .sm_state(sm_state),
    .rf_dataout(rf_dataout), .a_out(a_out), .g_out(g_out), .dp_out(dp_out),
    .adder_out(adder_out), .seg(seg), .an(an)
  );

  always #5 fpga_clk = ~fpga_clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    data_in = 0; imm = 0; addr_x = 0; addr_y = 0;
    rd_x = 0; rd_y = 0; wr_x = 0; a_in = 0; g_in = 0; dp_in = 0;
    add_sub = 0; iout = 0;
  endtask

  task automatic step();
    @(posedge fpga_clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [3:0] d);
    idle(); addr_x = a; data_in = d; wr_x = 1;
    step(); idle();
  endtask

  task automatic load_a(input logic [1:0] a);
    idle(); addr_x = a; rd_x = 1; a_in = 1;
    step(); idle();
  endtask

  initial begin
    idle();
    sm_state = 4'h5;
    reset = 1;
    #1;
    chk("rst_a", a_out, 0);
    chk("rst_g", g_out, 0);
    chk("rst_dp", dp_out, 0);
    chk("rst_an", an, 8'hFE);
    chk("rst_seg", seg, 7'h40);
    for (int i = 0; i < 4; i++) begin
      addr_x = i[1:0]; rd_x = 1; #1;
      chk("rst_rf", rf_dataout, 0);
    end
    idle();
    step(); step();
    reset = 0;
    step();

    // Same-cycle read sees old value; new value after the edge.
    idle(); addr_x = 0; data_in = 1; wr_x = 1; rd_x = 1; #1;
    chk("rd_before_wr", rf_dataout, 0);
    step();
    chk("rd_after_wr", rf_dataout, 1);
    wr(1, 2); wr(2, 4); wr(3, 8);
    for (int i = 0; i < 4; i++) begin
      idle(); addr_x = i[1:0]; rd_x = 1; #1;
      chk("load_rb", rf_dataout, 16'(1 << i));
    end
    idle(); addr_x = 1; addr_y = 3; rd_x = 1; rd_y = 1; #1;
    chk("rdx_prio", rf_dataout, 2);
    rd_x = 0; #1;
    chk("rdy_only", rf_dataout, 8);
    idle(); #1;
    chk("rd_none", rf_dataout, 0);

    // Move R2<=R3, then R2 = R2 + R1.
    wr(2, 8);
    load_a(2);
    chk("mv_a", a_out, 8);
    idle(); addr_y = 1; rd_y = 1; g_in = 1; #1;
    chk("add_out", adder_out, 10);
    step();
    chk("add_g", g_out, 10);
    wr(2, g_out);
    idle(); addr_x = 2; rd_x = 1; #1;
    chk("add_wb", rf_dataout, 10);

    // Hold when enables low.
    idle(); addr_x = 3; rd_x = 1; step();
    chk("hold_a", a_out, 8);
    chk("hold_g", g_out, 10);

    // Subtract and wrap-around.
    load_a(3);
    idle(); addr_x = 0; rd_x = 1; add_sub = 1; g_in = 1; #1;
    chk("sub_out", adder_out, 7);
    step();
    chk("sub_g", g_out, 7);
    idle(); a_in = 1; step();
    chk("a_zero", a_out, 0);
    idle(); addr_x = 0; rd_x = 1; add_sub = 1; #1;
    chk("sub_wrap", adder_out, 15);
    wr(1, 15);
    load_a(1);
    idle(); addr_x = 0; rd_x = 1; #1;
    chk("add_wrap", adder_out, 0);

    // Immediate operand.
    wr(3, 7);
    load_a(3);
    idle(); addr_x = 2; rd_x = 1; iout = 1; imm = 5; g_in = 1; #1;
    chk("imm_add", adder_out, 12);
    step();
    chk("imm_g", g_out, 12);
    wr(3, g_out);
    load_a(3);
    idle(); iout = 1; imm = 2; add_sub = 1; #1;
    chk("imm_sub", adder_out, 10);

    // Display.
    idle(); addr_x = 2; rd_x = 1; dp_in = 1; step(); idle();
    chk("dp_load", dp_out, 10);
    for (int c = 0; c < 40; c++) begin
      chk("an_onehot", 16'(an == 8'hFE || an == 8'hFD), 1);
      if (an == 8'hFE) begin
        saw0++;
        chk("seg_dp", seg, seg_tab[10]);
      end else if (an == 8'hFD) begin
        saw1++;
        chk("seg_state", seg, seg_tab[5]);
      end
      step();
    end
    chk("saw_dig0", 16'(saw0 > 0), 1);
    chk("saw_dig1", 16'(saw1 > 0), 1);

    // Async reset in the middle of a write.
    idle(); addr_x = 2; data_in = 9; wr_x = 1; g_in = 1; a_in = 1;
    #2 reset = 1;
    #1;
    chk("mid_a", a_out, 0);
    chk("mid_g", g_out, 0);
    chk("mid_dp", dp_out, 0);
    chk("mid_an", an, 8'hFE);
    step();
    wr_x = 0; rd_x = 1;
    for (int i = 0; i < 4; i++) begin
      addr_x = i[1:0]; #1;
      chk("mid_rf", rf_dataout, 0);
    end
    idle();
    reset = 0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
